// File: rtl/button_pkg.sv
// button_pkg: shared types and constants for the button conditioner.
//   debounce_state_t  : per-channel debounce FSM states (IDLE, COUNT)
//   DEF_STABLE_CYCLES : default stability window, 10 ms at 80 MHz
//   CLK_PERIOD_PS     : board clock period
package button_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } debounce_state_t;

    localparam int unsigned DEF_STABLE_CYCLES = 800000;
    localparam int unsigned CLK_PERIOD_PS     = 12500;

endpackage

// File: rtl/button_debounce_ch.sv
// button_debounce_ch: one button channel -- 2-flop synchronizer, debounce FSM
// with stability counter, registered level and optional rise/fall pulses.
// Optional feature macro: BUTTON_EDGE_EN (compiles in the rise/fall registers;
// otherwise o_rise/o_fall are constant 0).
// Ports:
//   clk     : clock
//   rst     : synchronous active-high reset
//   i_btn   : polarity-corrected asynchronous input, 1 = pressed
//   o_level : debounced level
//   o_rise  : one-cycle pulse on level 0->1
//   o_fall  : one-cycle pulse on level 1->0
module button_debounce_ch
    import button_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(STABLE_CYCLES - 1);

    logic            r_s1;
    logic            r_s2;
    logic            r_level;
    logic [CNT_W-1:0] r_cnt;
    debounce_state_t r_state;

    debounce_state_t  w_next_state;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_toggle;

    // Synchronizer: two flops, cleared to "released" on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
        end
    end

    // FSM, counter and level registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_level <= r_level ^ w_toggle;
        end
    end

    // Next state: every cycle with s2 != level counts; the STABLE_CYCLES-th
    // such consecutive cycle toggles level. Any agreeing cycle drops the count.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_toggle     = 1'b0;
        case (r_state)
            IDLE: begin
                w_next_cnt = '0;
                if (r_s2 != r_level) begin
                    if (STABLE_CYCLES == 1) begin
                        w_toggle = 1'b1;
                    end else begin
                        w_next_cnt   = CNT_W'(1);
                        w_next_state = COUNT;
                    end
                end
            end
            COUNT: begin
                if (r_s2 == r_level) begin
                    w_next_cnt   = '0;
                    w_next_state = IDLE;
                end else if (r_cnt == TERMINAL) begin
                    w_toggle     = 1'b1;
                    w_next_cnt   = '0;
                    w_next_state = IDLE;
                end else begin
                    w_next_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_next_cnt   = '0;
                w_next_state = IDLE;
            end
        endcase
    end

    assign o_level = r_level;

`ifdef BUTTON_EDGE_EN
    logic r_rise;
    logic r_fall;

    // Edge pulses register on the same edge that level changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_toggle & ~r_level;
            r_fall <= w_toggle & r_level;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;
`else
    assign o_rise = 1'b0;
    assign o_fall = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: conditions WIDTH raw button pins into clean debounced
// levels with optional rise/fall pulses; one independent channel per pin.
// Optional feature macro: BUTTON_EDGE_EN (rise/fall logic; otherwise tied 0).
// Ports:
//   clk     : clock
//   rst     : synchronous active-high reset
//   btn_raw : asynchronous raw pins
//   level   : debounced level, 1 = pressed
//   rise    : one-cycle pulse on level 0->1
//   fall    : one-cycle pulse on level 1->0
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned WIDTH         = 2,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] w_btn;

    // Polarity correction ahead of the synchronizers.
    assign w_btn = ACTIVE_LOW ? ~btn_raw : btn_raw;

    for (genvar g = 0; g < int'(WIDTH); g++) begin : g_ch
        button_debounce_ch #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .i_btn  (w_btn[g]),
            .o_level(level[g]),
            .o_rise (rise[g]),
            .o_fall (fall[g])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed scenarios with fixed expected timing plus a
// randomized run checked against a run-length reference model.
module tb_button_conditioner;

    localparam int S = 4;
`ifdef BUTTON_EDGE_EN
    localparam bit EDGE_ON = 1'b1;
`else
    localparam bit EDGE_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn_raw = 2'b11;
    logic [1:0] level, rise, fall;

    int checks = 0;
    int failures = 0;

    button_conditioner #(
        .WIDTH(2),
        .STABLE_CYCLES(S),
        .ACTIVE_LOW(1'b0)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_raw),
        .level  (level),
        .rise   (rise),
        .fall   (fall)
    );

    always #5 clk = ~clk;

    // Reference: the raw pin is seen two edges late; level flips once the
    // delayed value has disagreed with it for S consecutive edges.
    logic [1:0] m_d1 = '0, m_d2 = '0, m_level = '0, m_rise = '0, m_fall = '0;
    int m_run [2] = '{0, 0};

    always @(posedge clk) begin
        if (rst) begin
            m_d1 = '0; m_d2 = '0; m_level = '0; m_rise = '0; m_fall = '0;
            m_run[0] = 0; m_run[1] = 0;
        end else begin
            m_rise = '0;
            m_fall = '0;
            for (int ch = 0; ch < 2; ch++) begin
                if (m_d2[ch] != m_level[ch]) begin
                    m_run[ch] = m_run[ch] + 1;
                    if (m_run[ch] == S) begin
                        m_run[ch] = 0;
                        if (EDGE_ON) begin
                            m_rise[ch] = ~m_level[ch];
                            m_fall[ch] = m_level[ch];
                        end
                        m_level[ch] = ~m_level[ch];
                    end
                end else begin
                    m_run[ch] = 0;
                end
            end
            m_d2 = m_d1;
            m_d1 = btn_raw;
        end
    end

    task automatic settle(input logic [1:0] v);
        btn_raw = v;
        repeat (S + 6) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [1:0] exp_l, exp_r;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({level, rise, fall} !== 6'b0) begin
                failures++;
                $display("FAIL reset_hold: level=%b rise=%b fall=%b required all 0", level, rise, fall);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_l = (k >= S + 2) ? 2'b11 : 2'b00;
            exp_r = (EDGE_ON && k == S + 2) ? 2'b11 : 2'b00;
            checks++;
            if (level !== exp_l || rise !== exp_r || fall !== 2'b00) begin
                failures++;
                $display("FAIL reset_release edge %0d: level=%b rise=%b fall=%b required %b %b 00",
                         k, level, rise, fall, exp_l, exp_r);
            end
        end
    endtask

    task automatic test_clean_press();
        logic exp_l, exp_r;
        settle(2'b00);
        btn_raw = 2'b01;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            exp_l = (k >= S + 2);
            exp_r = EDGE_ON && (k == S + 2);
            checks++;
            if (level[0] !== exp_l || rise[0] !== exp_r || level[1] !== 1'b0 ||
                rise[1] !== 1'b0 || fall !== 2'b00) begin
                failures++;
                $display("FAIL clean_press edge %0d: level=%b rise=%b fall=%b required level0=%b rise0=%b others 0",
                         k, level, rise, fall, exp_l, exp_r);
            end
        end
    endtask

    task automatic test_bounce();
        int rises = 0;
        settle(2'b00);
        for (int b = 0; b < 4; b++) begin
            btn_raw = (b % 2 == 0) ? 2'b01 : 2'b00;
            repeat (2) begin
                @(negedge clk);
                rises += int'(rise[0]);
                checks++;
                if (level[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL bounce_hold: level0=%b required 0", level[0]);
                end
            end
        end
        btn_raw = 2'b01;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            rises += int'(rise[0]);
            checks++;
            if (level[0] !== (k >= S + 2)) begin
                failures++;
                $display("FAIL bounce_settle edge %0d: level0=%b required %b", k, level[0], k >= S + 2);
            end
        end
        checks++;
        if (rises != (EDGE_ON ? 1 : 0)) begin
            failures++;
            $display("FAIL bounce_rise_count: got %0d required %0d", rises, EDGE_ON ? 1 : 0);
        end
    endtask

    task automatic test_glitch();
        settle(2'b00);
        btn_raw = 2'b10;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 3) btn_raw = 2'b00;
            checks++;
            if (level[1] !== 1'b0 || rise[1] !== 1'b0 || fall[1] !== 1'b0) begin
                failures++;
                $display("FAIL glitch edge %0d: level1=%b rise1=%b fall1=%b required 0",
                         k, level[1], rise[1], fall[1]);
            end
        end
    endtask

    task automatic test_simul_release();
        logic [1:0] exp_l, exp_f;
        settle(2'b11);
        checks++;
        if (level !== 2'b11) begin
            failures++;
            $display("FAIL simul_setup: level=%b required 11", level);
        end
        btn_raw = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_l = (k >= S + 2) ? 2'b00 : 2'b11;
            exp_f = (EDGE_ON && k == S + 2) ? 2'b11 : 2'b00;
            checks++;
            if (level !== exp_l || fall !== exp_f || rise !== 2'b00) begin
                failures++;
                $display("FAIL simul_release edge %0d: level=%b fall=%b rise=%b required %b %b 00",
                         k, level, fall, rise, exp_l, exp_f);
            end
        end
    endtask

    task automatic test_reset_mid();
        settle(2'b00);
        btn_raw = 2'b01;
        repeat (S + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (level !== 2'b00 || rise !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid_during: level=%b rise=%b required 00 00", level, rise);
        end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (level[0] !== (k >= S + 2) || rise[0] !== (EDGE_ON && k == S + 2)) begin
                failures++;
                $display("FAIL reset_mid edge %0d: level0=%b rise0=%b required %b %b",
                         k, level[0], rise[0], k >= S + 2, EDGE_ON && k == S + 2);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] v = '0;
        int hold = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            checks++;
            if (level !== m_level || rise !== m_rise || fall !== m_fall) begin
                failures++;
                $display("FAIL random cycle %0d: level=%b rise=%b fall=%b required %b %b %b",
                         i, level, rise, fall, m_level, m_rise, m_fall);
            end
            if (hold == 0) begin
                v    = 2'($urandom);
                hold = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 3))
                                                   : int'($urandom_range(4, 12));
            end
            hold--;
            btn_raw = v;
            rst = ($urandom_range(0, 99) == 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_simul_release();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
